// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-state encoding, default geometry and divider width.
package uart_pkg;

   localparam int unsigned DEF_D_W    = 8;
   localparam int unsigned DEF_B_TICK = 16;
   localparam int unsigned BRG_W      = 16;

   typedef enum logic [2:0] {
      StIdle,
      StPop,
      StLoad,
      StStart,
      StData,
      StParity,
      StStop
   } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Baud tick divider: pulses tick once every brg+1 clocks; clear restarts the count.
module uart_baud_gen
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic [BRG_W-1:0] brg,
   input  logic             clear,
   output logic             tick
);

   logic [BRG_W-1:0] cnt_q, cnt_d;

   // >= rather than == so a divisor lowered mid-count still wraps promptly
   assign tick = !clear && (cnt_q >= brg);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clear || (cnt_q >= brg)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: pops bytes from the TX FIFO and serialises start, data, parity and stop bits.
module uart_tx
   import uart_pkg::*;
#(
   parameter int unsigned D_W    = DEF_D_W,
   parameter int unsigned B_TICK = DEF_B_TICK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [BRG_W-1:0] brg,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   input  logic             fifo_empty,
   input  logic [D_W-1:0]   fifo_data,
   output logic             fifo_rd_en,
   output logic             tx,
   output logic             busy,
   output logic             tx_done
);

   localparam int unsigned TICK_W = (B_TICK > 1) ? $clog2(B_TICK) : 1;
   localparam int unsigned BIT_W  = $clog2(D_W + 1);

   state_t              state_q, state_d;
   logic [D_W-1:0]      shreg_q, shreg_d;
   logic                par_q, par_d;
   logic                parity_en_q, parity_en_d;
   logic                parity_odd_q, parity_odd_d;
   logic                stop2_q, stop2_d;
   logic [BRG_W-1:0]    brg_q, brg_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [BIT_W-1:0]    bit_cnt_q, bit_cnt_d;
   logic                done_q, done_d;
   logic                tick;
   logic                bit_end;

   // Clearing during LOAD makes the first START clock count 0 of a fresh bit
   uart_baud_gen u_baud_gen (
      .clk   (clk),
      .rst   (rst),
      .brg   (brg_q),
      .clear (state_q == StLoad),
      .tick  (tick)
   );

   assign bit_end = tick && (tick_cnt_q == TICK_W'(B_TICK - 1));

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      par_d        = par_q;
      parity_en_d  = parity_en_q;
      parity_odd_d = parity_odd_q;
      stop2_d      = stop2_q;
      brg_d        = brg_q;
      bit_cnt_d    = bit_cnt_q;
      done_d       = 1'b0;

      tick_cnt_d = tick_cnt_q;
      if (state_q == StLoad || bit_end) begin
         tick_cnt_d = '0;
      end else if (tick) begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end

      case (state_q)
         StIdle: begin
            if (en && !fifo_empty) begin
               state_d = StPop;
            end
         end
         StPop: state_d = StLoad;
         StLoad: begin
            shreg_d      = fifo_data;
            par_d        = ^fifo_data;
            parity_en_d  = parity_en;
            parity_odd_d = parity_odd;
            stop2_d      = stop2;
            brg_d        = brg;
            bit_cnt_d    = '0;
            state_d      = StStart;
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
            end
         end
         StData: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == BIT_W'(D_W - 1)) begin
                  bit_cnt_d = '0;
                  state_d   = parity_en_q ? StParity : StStop;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
            end
         end
         StStop: begin
            if (bit_end) begin
               // bit_cnt doubles as the stop-bit index
               if (stop2_q && (bit_cnt_q == '0)) begin
                  bit_cnt_d = 1'b1;
               end else begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
                  state_d   = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      tx = 1'b1;
      case (state_q)
         StStart:  tx = 1'b0;
         StData:   tx = shreg_q[0];
         StParity: tx = par_q ^ parity_odd_q;
         default:  tx = 1'b1;
      endcase
   end

   assign busy       = (state_q != StIdle);
   assign fifo_rd_en = (state_q == StPop);
   assign tx_done    = done_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         par_q        <= 1'b0;
         parity_en_q  <= 1'b0;
         parity_odd_q <= 1'b0;
         stop2_q      <= 1'b0;
         brg_q        <= '0;
         tick_cnt_q   <= '0;
         bit_cnt_q    <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         par_q        <= par_d;
         parity_en_q  <= parity_en_d;
         parity_odd_q <= parity_odd_d;
         stop2_q      <= stop2_d;
         brg_q        <= brg_d;
         tick_cnt_q   <= tick_cnt_d;
         bit_cnt_q    <= bit_cnt_d;
         done_q       <= done_d;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a small behavioural TX FIFO in front of it.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        en = 1'b0;
   logic [15:0] brg = '0;
   logic        parity_en = 1'b0;
   logic        parity_odd = 1'b0;
   logic        stop2 = 1'b0;
   logic        fifo_empty;
   logic [7:0]  fifo_data = '0;
   logic        fifo_rd_en;
   logic        tx;
   logic        busy;
   logic        tx_done;

   int n_checks = 0;
   int n_fail = 0;

   logic [7:0] mem [0:15];
   int wr_ptr = 0;
   int rd_ptr = 0;
   int rd_pulses = 0;
   int done_pulses = 0;

   uart_tx #(.D_W(8), .B_TICK(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .brg        (brg),
      .parity_en  (parity_en),
      .parity_odd (parity_odd),
      .stop2      (stop2),
      .fifo_empty (fifo_empty),
      .fifo_data  (fifo_data),
      .fifo_rd_en (fifo_rd_en),
      .tx         (tx),
      .busy       (busy),
      .tx_done    (tx_done)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en) begin
         fifo_data <= mem[rd_ptr[3:0]];
         rd_ptr    <= rd_ptr + 1;
         rd_pulses <= rd_pulses + 1;
      end
      if (tx_done) done_pulses <= done_pulses + 1;
   end

   task automatic push(input logic [7:0] d);
      mem[wr_ptr[3:0]] = d;
      wr_ptr = wr_ptr + 1;
   endtask

   // Returns at the negedge of the first START clock
   task automatic wait_start(input int limit, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < limit; i++) begin
         @(negedge clk);
         if (tx === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL reset_tx got %b want 1", tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", tx_done); end
      n_checks++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      logic [9:0] exp;
      int bad, r0;
      bit ok;
      exp = {1'b1, 8'h55, 1'b0};
      brg = 16'd0; parity_en = 1'b0; stop2 = 1'b0;
      r0 = rd_pulses;
      push(8'h55);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL basic_start got timeout want start bit"); return; end
      bad = 0;
      for (int c = 0; c < 160; c++) begin
         if (tx !== exp[c / 16]) bad++;
         if (c == 159 && tx_done !== 1'b0) bad++;
         @(negedge clk);
      end
      if (bad != 0) begin n_fail++; $display("FAIL basic_frame got %0d bad clocks want 0", bad); end
      n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL basic_done_160 got %b want 1", tx_done); end
      n_checks++; if (rd_pulses - r0 != 1) begin n_fail++; $display("FAIL basic_rd_en got %0d want 1", rd_pulses - r0); end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL basic_empty got %b want 1", fifo_empty); end
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_parity_stop2;
      logic [11:0] exp;
      int bad_tx, bad_busy;
      bit ok;
      // 0x07 has odd weight, so even parity sends 1
      exp = {2'b11, 1'b1, 8'h07, 1'b0};
      brg = 16'd3; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
      push(8'h07);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL par_start got timeout want start bit"); return; end
      bad_tx = 0; bad_busy = 0;
      for (int c = 0; c < 768; c++) begin
         if (tx !== exp[c / 64]) bad_tx++;
         if (busy !== 1'b1) bad_busy++;
         if (c == 100) begin parity_en = 1'b0; stop2 = 1'b0; brg = 16'd0; end
         @(negedge clk);
      end
      if (bad_tx != 0) begin n_fail++; $display("FAIL par_frame got %0d bad clocks want 0", bad_tx); end
      n_checks++; if (bad_busy != 0) begin n_fail++; $display("FAIL par_busy got %0d low clocks want 0", bad_busy); end
      n_checks++; if (tx_done !== 1'b1) begin n_fail++; $display("FAIL par_done_768 got %b want 1", tx_done); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL par_busy_end got %b want 0", busy); end
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_parity_values;
      logic [10:0] exp_odd, exp_even;
      int bad;
      bit ok;
      exp_odd  = {1'b1, 1'b1, 8'h00, 1'b0};
      exp_even = {1'b1, 1'b0, 8'hFF, 1'b0};
      brg = 16'd0; parity_en = 1'b1; parity_odd = 1'b1; stop2 = 1'b0;
      push(8'h00);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      bad = ok ? 0 : 1;
      for (int c = 0; ok && c < 176; c++) begin
         if (tx !== exp_odd[c / 16]) bad++;
         @(negedge clk);
      end
      if (bad != 0) begin n_fail++; $display("FAIL odd_00 got %0d bad clocks want 0", bad); end
      en = 1'b0;
      repeat (3) @(negedge clk);
      parity_odd = 1'b0;
      push(8'hFF);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      bad = ok ? 0 : 1;
      for (int c = 0; ok && c < 176; c++) begin
         if (tx !== exp_even[c / 16]) bad++;
         @(negedge clk);
      end
      if (bad != 0) begin n_fail++; $display("FAIL even_ff got %0d bad clocks want 0", bad); end
      en = 1'b0;
      parity_en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [9:0] exp1, exp2;
      int bad1, bad2, gap, d0;
      bit ok;
      exp1 = {1'b1, 8'hA5, 1'b0};
      exp2 = {1'b1, 8'h3C, 1'b0};
      brg = 16'd0; parity_en = 1'b0; stop2 = 1'b0;
      d0 = done_pulses;
      push(8'hA5);
      push(8'h3C);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL b2b_start got timeout want start bit"); return; end
      bad1 = 0;
      for (int c = 0; c < 160; c++) begin
         if (tx !== exp1[c / 16]) bad1++;
         @(negedge clk);
      end
      if (bad1 != 0) begin n_fail++; $display("FAIL b2b_frame1 got %0d bad clocks want 0", bad1); end
      gap = 0;
      while (tx === 1'b1 && gap < 50) begin
         gap++;
         @(negedge clk);
      end
      n_checks++; if (gap != 3) begin n_fail++; $display("FAIL b2b_gap got %0d want 3", gap); end
      bad2 = 0;
      for (int c = 0; c < 160; c++) begin
         if (tx !== exp2[c / 16]) bad2++;
         @(negedge clk);
      end
      n_checks++; if (bad2 != 0) begin n_fail++; $display("FAIL b2b_frame2 got %0d bad clocks want 0", bad2); end
      @(negedge clk);
      n_checks++; if (done_pulses - d0 != 2) begin n_fail++; $display("FAIL b2b_done got %0d want 2", done_pulses - d0); end
      en = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_en_drop;
      int r0, lows, waited;
      bit ok;
      brg = 16'd0;
      r0 = rd_pulses;
      push(8'h11);
      push(8'h22);
      push(8'h33);
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL endrop_start got timeout want start bit"); return; end
      repeat (40) @(negedge clk);
      en = 1'b0;
      waited = 0;
      while (tx_done !== 1'b1 && waited < 300) begin
         waited++;
         @(negedge clk);
      end
      if (waited >= 300) begin n_fail++; $display("FAIL endrop_done got timeout want tx_done"); end
      lows = 0;
      for (int c = 0; c < 100; c++) begin
         if (tx !== 1'b1) lows++;
         @(negedge clk);
      end
      n_checks++; if (lows != 0) begin n_fail++; $display("FAIL endrop_idle got %0d low clocks want 0", lows); end
      n_checks++; if (rd_pulses - r0 != 1) begin n_fail++; $display("FAIL endrop_rd got %0d want 1", rd_pulses - r0); end
   endtask

   task automatic test_reset_mid;
      logic [9:0] exp;
      int lows, r0, bad;
      bit ok;
      exp = {1'b1, 8'h33, 1'b0};
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL rstmid_start got timeout want start bit"); return; end
      repeat (50) @(negedge clk);
      // Clock 50 sits in data bit 2 of 0x22, which is 0
      if (tx !== 1'b0) begin n_fail++; $display("FAIL rstmid_pre got %b want 0", tx); end
      #1 rst = 1'b0;
      #1;
      n_checks++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rstmid_tx got %b want 1", tx); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      en = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      r0 = rd_pulses;
      lows = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      n_checks++;
      if (lows != 0 || rd_pulses != r0) begin
         n_fail++; $display("FAIL rstmid_idle got %0d lows %0d pops want 0 0", lows, rd_pulses - r0);
      end
      en = 1'b1;
      wait_start(20, ok);
      n_checks++;
      bad = ok ? 0 : 1;
      for (int c = 0; ok && c < 160; c++) begin
         if (tx !== exp[c / 16]) bad++;
         @(negedge clk);
      end
      if (bad != 0) begin n_fail++; $display("FAIL rstmid_next got %0d bad clocks want 0 (byte 0x33)", bad); end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty got %b want 1", fifo_empty); end
      en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_parity_stop2();
      test_parity_values();
      test_back_to_back();
      test_en_drop();
      test_reset_mid();
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
